ifetch_prefetch: RTL and testbench

//   Parametrised next-generation instruction fetch unit with a pipelined bus handshake and a prefetch FIFO.

---
 rtl/ifetch_prefetch_if.sv | 55 +++++
 rtl/ifetch_prefetch.sv | 206 ++++++++++++++++++++
 tb/tb_ifetch_prefetch.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_prefetch_if.sv
// ---------------------------------------------------------------------------
// ifetch_prefetch_if
//   Instruction bus between the prefetching fetch unit (master) and the
//   instruction memory / interconnect (slave).
//
//   Handshake (request/grant with in-order responses):
//     - A request is accepted in every cycle where O_ibus_req and I_ibus_gnt
//       are both high at the rising clock edge. O_ibus_addr is the address of
//       that request. While a request is pending and not granted, the master
//       keeps O_ibus_addr stable; req drops only because of halt or redirect.
//     - Every accepted request gets exactly one response, in request order.
//       I_ibus_rvalid marks the cycle carrying I_ibus_data / I_ibus_err. At
//       most one response per cycle, never in the same cycle as its grant.
//     - Responses cannot be back-pressured; the master reserves buffer space
//       at issue time so that it can always take them.
//
//   Signals
//     O_ibus_req     master -> slave  fetch request
//     O_ibus_addr    master -> slave  word-aligned fetch address
//     I_ibus_gnt     slave -> master  request accepted this cycle (with req)
//     I_ibus_rvalid  slave -> master  response valid
//     I_ibus_data    slave -> master  response instruction word
//     I_ibus_err     slave -> master  response bus error
// ---------------------------------------------------------------------------
interface ifetch_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) ();

  logic              O_ibus_req;
  logic [ADDR_W-1:0] O_ibus_addr;
  logic              I_ibus_gnt;
  logic              I_ibus_rvalid;
  logic [INST_W-1:0] I_ibus_data;
  logic              I_ibus_err;

  modport master (
    output O_ibus_req,
    output O_ibus_addr,
    input  I_ibus_gnt,
    input  I_ibus_rvalid,
    input  I_ibus_data,
    input  I_ibus_err
  );

  modport slave (
    input  O_ibus_req,
    input  O_ibus_addr,
    output I_ibus_gnt,
    output I_ibus_rvalid,
    output I_ibus_data,
    output I_ibus_err
  );

endinterface

// File: rtl/ifetch_prefetch.sv
// ---------------------------------------------------------------------------
// ifetch_prefetch
//   Instruction fetch unit with a pipelined request/grant bus and a prefetch
//   FIFO. Word fetches are issued ahead of decode, up to MAX_OUTSTANDING are
//   kept in flight, and returned instructions are buffered together with
//   their PC and bus-error flag. Flush and branch redirects restart fetching
//   at the new target; responses to requests already on the bus are counted
//   and dropped when they arrive instead of aborting the bus.
//
//   Ports
//     clk, rst          clock, asynchronous active-high reset
//     I_flush           pipeline flush, redirect to I_flush_addr (priority)
//     I_flush_addr      flush target
//     I_bru_taken       taken branch/jump, redirect to I_bru_target
//     I_bru_target      branch target
//     I_jtag_halt       stop issuing new requests (in-flight ones complete)
//     I_stall           decode not ready, head entry is held
//     O_inst_valid      head entry valid (O_inst / O_inst_addr / O_inst_err)
//     O_inst            head instruction
//     O_inst_addr       PC of the head instruction
//     O_inst_err        bus error reported for the head instruction
//     ibus              instruction bus, master side (see ifetch_prefetch_if)
// ---------------------------------------------------------------------------
module ifetch_prefetch #(
  parameter int                ADDR_W          = 32,
  parameter int                INST_W          = 32,
  parameter logic [ADDR_W-1:0] RESET_PC        = 32'h8000_0000,
  parameter int                FIFO_DEPTH      = 4,
  parameter int                MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  I_flush,
  input  logic [ADDR_W-1:0]     I_flush_addr,
  input  logic                  I_bru_taken,
  input  logic [ADDR_W-1:0]     I_bru_target,
  input  logic                  I_jtag_halt,
  input  logic                  I_stall,
  output logic                  O_inst_valid,
  output logic [INST_W-1:0]     O_inst,
  output logic [ADDR_W-1:0]     O_inst_addr,
  output logic                  O_inst_err,
  ifetch_prefetch_if.master     ibus
);

  // FIFO_DEPTH is a power of two, so the FIFO pointers wrap naturally.
  localparam int FA_W  = $clog2(FIFO_DEPTH);
  localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int OC_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SUM_W = FC_W + OC_W + 1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] fetch_pc;
  // Granted requests whose response has not arrived yet (stale ones included).
  logic [OC_W-1:0]   outstanding;
  // How many of the outstanding responses belong to a pre-redirect stream.
  // Always <= outstanding.
  logic [OC_W-1:0]   discard;

  // In-flight PC queue: PC of every granted request, in grant order.
  logic [ADDR_W-1:0] pc_q [MAX_OUTSTANDING];
  logic [PQ_W-1:0]   pq_wr;
  logic [PQ_W-1:0]   pq_rd;

  // Prefetch FIFO.
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
  logic [INST_W-1:0] fifo_data [FIFO_DEPTH];
  logic              fifo_err  [FIFO_DEPTH];
  logic [FA_W-1:0]   fifo_wr;
  logic [FA_W-1:0]   fifo_rd;
  logic [FC_W-1:0]   fifo_count;

  // -------------------------------------------------------------------------
  // Control
  // -------------------------------------------------------------------------
  logic              redir;
  logic [ADDR_W-1:0] redir_target;
  logic [SUM_W-1:0]  live_slots;
  logic              issue_ok;
  logic              grant;
  logic              rsp;
  logic              drop;
  logic              push;
  logic              pop;

  assign redir        = I_flush | I_bru_taken;
  assign redir_target = I_flush ? {I_flush_addr[ADDR_W-1:2], 2'b00}
                                : {I_bru_target[ADDR_W-1:2], 2'b00};

  // FIFO slots already spoken for: buffered entries plus live (non-discarded)
  // requests on the bus. Reserving at issue means a live response always has
  // room, so the bus never has to be back-pressured.
  assign live_slots = SUM_W'(fifo_count) + SUM_W'(outstanding) - SUM_W'(discard);
  assign issue_ok   = (outstanding < OC_W'(MAX_OUTSTANDING)) &&
                      (live_slots < SUM_W'(FIFO_DEPTH));

  // Request is held low in a redirect cycle, so a grant never coincides with
  // a redirect and fetch_pc has a single update source per cycle.
  assign ibus.O_ibus_req  = ~rst & ~I_jtag_halt & ~redir & issue_ok;
  assign ibus.O_ibus_addr = fetch_pc;

  assign grant = ibus.O_ibus_req & ibus.I_ibus_gnt;
  // A response with nothing outstanding (e.g. for a request issued before
  // reset) is not ours and is ignored.
  assign rsp   = ibus.I_ibus_rvalid & (outstanding != '0);
  assign drop  = rsp & (redir | (discard != '0));
  assign push  = rsp & ~drop;

  assign O_inst_valid = (fifo_count != '0) & ~redir;
  assign pop          = O_inst_valid & ~I_stall;

  assign O_inst      = fifo_data[fifo_rd];
  assign O_inst_addr = fifo_pc[fifo_rd];
  assign O_inst_err  = fifo_err[fifo_rd];

  function automatic logic [PQ_W-1:0] pq_next(input logic [PQ_W-1:0] p);
    return (p == PQ_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PQ_W'(1);
  endfunction

  // -------------------------------------------------------------------------
  // Fetch PC, outstanding and discard counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + OC_W'(grant) - OC_W'(rsp);
      if (redir) begin
        fetch_pc <= redir_target;
        // Every request still on the bus after this cycle belongs to the old
        // stream, including ones already marked for discard.
        discard  <= outstanding - OC_W'(rsp);
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + ADDR_W'(4);
        end
        if (rsp && (discard != '0)) begin
          discard <= discard - OC_W'(1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // In-flight PC queue. Stale entries are popped by their (dropped) responses
  // just like live ones, so the queue never needs clearing on redirect.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pq_wr <= '0;
      pq_rd <= '0;
    end else begin
      if (grant) begin
        pq_wr <= pq_next(pq_wr);
      end
      if (rsp) begin
        pq_rd <= pq_next(pq_rd);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      pc_q[pq_wr] <= fetch_pc;
    end
  end

  // -------------------------------------------------------------------------
  // Prefetch FIFO. Storage is reset so the head outputs read as zero after
  // reset. No bypass: a response written this cycle is visible next cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_data[i] <= '0;
        fifo_err[i]  <= 1'b0;
      end
    end else if (redir) begin
      // Buffered entries belong to the old stream; stall does not protect them.
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_pc[fifo_wr]   <= pc_q[pq_rd];
        fifo_data[fifo_wr] <= ibus.I_ibus_data;
        fifo_err[fifo_wr]  <= ibus.I_ibus_err;
        fifo_wr            <= fifo_wr + FA_W'(1);
      end
      if (pop) begin
        fifo_rd <= fifo_rd + FA_W'(1);
      end
      fifo_count <= fifo_count + FC_W'(push) - FC_W'(pop);
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch_prefetch
//   Directed bench for ifetch_prefetch (FIFO_DEPTH 4, MAX_OUTSTANDING 2).
//   Inputs change 1 time unit after the rising edge; outputs are checked on
//   the falling edge. The bus slave answers each granted request in order,
//   starting the cycle after the grant, unless rsp_hold keeps it silent.
//   Instruction data for address a is a ^ 32'h5A5A_0000.
// ---------------------------------------------------------------------------
module tb_ifetch_prefetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] flush_addr;
  logic        bru_taken;
  logic [31:0] bru_target;
  logic        halt;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_err;

  ifetch_prefetch_if #(.ADDR_W(32), .INST_W(32)) ibus ();

  ifetch_prefetch #(
    .ADDR_W(32), .INST_W(32), .RESET_PC(32'h8000_0000),
    .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst),
    .I_flush(flush), .I_flush_addr(flush_addr),
    .I_bru_taken(bru_taken), .I_bru_target(bru_target),
    .I_jtag_halt(halt), .I_stall(stall),
    .O_inst_valid(inst_valid), .O_inst(inst),
    .O_inst_addr(inst_addr), .O_inst_err(inst_err),
    .ibus(ibus)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] pend_q[$];
  logic        rsp_hold;
  logic [31:0] err_addr;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] a, input logic e);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
    chk({tag, "_pc"}, inst_addr, a);
    chk({tag, "_inst"}, inst, inst_of(a));
    chk({tag, "_err"}, 32'(inst_err), 32'(e));
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  // Called at the falling edge: note any grant, cross the rising edge, then
  // play the bus slave for the following cycle.
  task automatic adv();
    logic        g;
    logic [31:0] ga;
    logic [31:0] a;
    g  = ibus.O_ibus_req & ibus.I_ibus_gnt;
    ga = ibus.O_ibus_addr;
    @(posedge clk);
    #1;
    if (g) pend_q.push_back(ga);
    if (!rsp_hold && pend_q.size() != 0) begin
      a = pend_q.pop_front();
      ibus.I_ibus_rvalid = 1'b1;
      ibus.I_ibus_data   = inst_of(a);
      ibus.I_ibus_err    = (a == err_addr);
    end else begin
      ibus.I_ibus_rvalid = 1'b0;
      ibus.I_ibus_data   = '0;
      ibus.I_ibus_err    = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    flush      = 1'b0;
    flush_addr = '0;
    bru_taken  = 1'b0;
    bru_target = '0;
    halt       = 1'b0;
    stall      = 1'b0;
    rsp_hold   = 1'b0;
    err_addr   = 32'hFFFF_FFFF;
    pend_q.delete();
    ibus.I_ibus_gnt    = 1'b0;
    ibus.I_ibus_rvalid = 1'b0;
    ibus.I_ibus_data   = '0;
    ibus.I_ibus_err    = 1'b0;
    to_neg();
    chk("rst_req", 32'(ibus.O_ibus_req), 32'd0);
    chk("rst_addr", ibus.O_ibus_addr, RST_PC);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_addr, 32'd0);
    chk("rst_err", 32'(inst_err), 32'd0);
    adv();
    to_neg();
    adv();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;

    // T1: streaming, one instruction per cycle, 2-cycle req -> head latency
    do_reset();
    ibus.I_ibus_gnt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      to_neg();
      chk("t1_req", 32'(ibus.O_ibus_req), 32'd1);
      chk("t1_addr", ibus.O_ibus_addr, RST_PC + 32'(4 * i));
      if (i < 2) chk("t1_valid", 32'(inst_valid), 32'd0);
      else       chk_head("t1_head", RST_PC + 32'(4 * (i - 2)), 1'b0);
      adv();
    end

    // T2: stall fills the FIFO (A6..A9), req stops, then an in-order drain
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      to_neg();
      if (i < 2) chk("t2_req_fill", 32'(ibus.O_ibus_req), 32'd1);
      else       chk("t2_req_full", 32'(ibus.O_ibus_req), 32'd0);
      if (i == 9) chk_head("t2_held", RST_PC + 32'h18, 1'b0);
      adv();
    end
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      to_neg();
      chk_head("t2_drain", RST_PC + 32'h18 + 32'(4 * i), 1'b0);
      if (i == 0) chk("t2_req_still_full", 32'(ibus.O_ibus_req), 32'd0);
      if (i == 1) begin
        chk("t2_req_resume", 32'(ibus.O_ibus_req), 32'd1);
        chk("t2_addr_resume", ibus.O_ibus_addr, RST_PC + 32'h28);
      end
      adv();
    end

    // T3: two in flight, branch taken, both stale responses dropped
    do_reset();
    ibus.I_ibus_gnt = 1'b1;
    rsp_hold = 1'b1;
    to_neg(); chk("t3_req0", 32'(ibus.O_ibus_req), 32'd1); adv();
    to_neg(); chk("t3_addr1", ibus.O_ibus_addr, RST_PC + 32'h4); adv();
    to_neg(); chk("t3_req_max_out", 32'(ibus.O_ibus_req), 32'd0); adv();
    bru_taken  = 1'b1;
    bru_target = 32'h8000_0102;
    rsp_hold   = 1'b0;
    to_neg();
    chk("t3_req_redir", 32'(ibus.O_ibus_req), 32'd0);
    adv();
    bru_taken = 1'b0;
    to_neg();
    chk("t3_addr_target", ibus.O_ibus_addr, 32'h8000_0100);
    chk("t3_req_wait", 32'(ibus.O_ibus_req), 32'd0);
    chk("t3_valid_drop0", 32'(inst_valid), 32'd0);
    adv();
    to_neg();
    chk("t3_req_target", 32'(ibus.O_ibus_req), 32'd1);
    chk("t3_valid_drop1", 32'(inst_valid), 32'd0);
    adv();
    to_neg();
    chk("t3_valid_drop2", 32'(inst_valid), 32'd0);
    chk("t3_addr_next", ibus.O_ibus_addr, 32'h8000_0104);
    adv();
    to_neg(); chk_head("t3_first", 32'h8000_0100, 1'b0); adv();
    to_neg(); chk_head("t3_second", 32'h8000_0104, 1'b0); adv();

    // T4: flush and branch together with a response in the same cycle
    do_reset();
    ibus.I_ibus_gnt = 1'b1;
    to_neg(); chk("t4_req0", 32'(ibus.O_ibus_req), 32'd1); adv();
    flush      = 1'b1;
    flush_addr = 32'h8000_0200;
    bru_taken  = 1'b1;
    bru_target = 32'h8000_0300;
    to_neg();
    chk("t4_rvalid_seen", 32'(ibus.I_ibus_rvalid), 32'd1);
    chk("t4_req_redir", 32'(ibus.O_ibus_req), 32'd0);
    adv();
    flush     = 1'b0;
    bru_taken = 1'b0;
    to_neg();
    chk("t4_req_plus1", 32'(ibus.O_ibus_req), 32'd1);
    chk("t4_addr_flush", ibus.O_ibus_addr, 32'h8000_0200);
    chk("t4_valid_drop", 32'(inst_valid), 32'd0);
    adv();
    to_neg(); chk("t4_valid_fill", 32'(inst_valid), 32'd0); adv();
    to_neg(); chk_head("t4_first", 32'h8000_0200, 1'b0); adv();

    // T5: halt with two in flight, responses buffered, drain, resume
    do_reset();
    ibus.I_ibus_gnt = 1'b1;
    rsp_hold = 1'b1;
    stall    = 1'b1;
    to_neg(); adv();
    to_neg(); adv();
    halt     = 1'b1;
    rsp_hold = 1'b0;
    to_neg(); chk("t5_req_halt0", 32'(ibus.O_ibus_req), 32'd0); adv();
    to_neg();
    chk("t5_req_halt1", 32'(ibus.O_ibus_req), 32'd0);
    chk("t5_valid_fill", 32'(inst_valid), 32'd0);
    adv();
    to_neg(); chk_head("t5_buf0", RST_PC, 1'b0); adv();
    to_neg();
    chk("t5_req_halt2", 32'(ibus.O_ibus_req), 32'd0);
    chk_head("t5_buf1", RST_PC, 1'b0);
    adv();
    stall = 1'b0;
    to_neg(); chk_head("t5_pop0", RST_PC, 1'b0); adv();
    to_neg(); chk_head("t5_pop1", RST_PC + 32'h4, 1'b0); adv();
    to_neg();
    chk("t5_empty", 32'(inst_valid), 32'd0);
    chk("t5_req_halt3", 32'(ibus.O_ibus_req), 32'd0);
    adv();
    halt = 1'b0;
    to_neg();
    chk("t5_req_resume", 32'(ibus.O_ibus_req), 32'd1);
    chk("t5_addr_resume", ibus.O_ibus_addr, RST_PC + 32'h8);
    adv();

    // T5b: flush while stalled with a non-empty FIFO still clears it
    do_reset();
    ibus.I_ibus_gnt = 1'b1;
    stall = 1'b1;
    to_neg(); adv();
    to_neg(); adv();
    to_neg(); adv();
    to_neg(); chk_head("t5b_head", RST_PC, 1'b0); adv();
    flush      = 1'b1;
    flush_addr = 32'h8000_0400;
    to_neg(); chk("t5b_valid_redir", 32'(inst_valid), 32'd0); adv();
    flush = 1'b0;
    to_neg();
    chk("t5b_valid_cleared", 32'(inst_valid), 32'd0);
    chk("t5b_req", 32'(ibus.O_ibus_req), 32'd1);
    chk("t5b_addr", ibus.O_ibus_addr, 32'h8000_0400);
    adv();

    // T6: bus error on 0x80000008 only, then grant held low for 5 cycles
    do_reset();
    ibus.I_ibus_gnt = 1'b1;
    err_addr = 32'h8000_0008;
    for (int i = 0; i < 6; i++) begin
      to_neg();
      chk("t6_addr", ibus.O_ibus_addr, RST_PC + 32'(4 * i));
      if (i >= 2) chk_head("t6_head", RST_PC + 32'(4 * (i - 2)), (i == 4));
      adv();
    end
    ibus.I_ibus_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      to_neg();
      chk("t6_req_nognt", 32'(ibus.O_ibus_req), 32'd1);
      chk("t6_addr_stable", ibus.O_ibus_addr, RST_PC + 32'h18);
      adv();
    end
    ibus.I_ibus_gnt = 1'b1;
    to_neg(); chk("t6_addr_gnt", ibus.O_ibus_addr, RST_PC + 32'h18); adv();
    to_neg(); chk("t6_addr_after", ibus.O_ibus_addr, RST_PC + 32'h1C); adv();

    // Reset in the middle of traffic drops everything
    do_reset();
    to_neg();
    chk("post_rst_valid", 32'(inst_valid), 32'd0);
    chk("post_rst_addr", ibus.O_ibus_addr, RST_PC);
    adv();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
